// File: rtl/scan_window_gate.sv
// Gates the per-revolution point stream to the latched scan window and queues tagged points for the packet builder.
// Optional macro SCAN_GATE_COUNT_CHECK_EN adds o_count_err (accepted count vs. expected count per completed frame).
module scan_window_gate #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic [15:0]       i_start_index,
    input  logic [15:0]       i_stop_index,
    input  logic [15:0]       i_index_num,
    input  logic              i_frame_sync,
    input  logic              i_point_valid,
    input  logic [DATA_W-1:0] i_point_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [15:0]       o_index,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_overflow,
    output logic              o_short_frame
`ifdef SCAN_GATE_COUNT_CHECK_EN
    ,
    output logic              o_count_err
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_W + 18;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, PASS, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         acc_q, acc_d;
    logic [15:0]         lo_q, lo_d, hi_q, hi_d, num_q, num_d;
    logic                short_q, short_d;
    logic                ovf_q, ovf_d;
    logic                s0_valid_q, s0_valid_d, s0_sof_q, s0_sof_d, s0_eof_q, s0_eof_d;
    logic [15:0]         s0_index_q, s0_index_d;
    logic [DATA_W-1:0]   s0_data_q, s0_data_d;
    logic                s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
    logic [15:0]         s1_index_q, s1_index_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

    // Effective per-point view: a coincident sync applies before the point is judged.
    logic [15:0]         cur_lo, cur_hi, cur_num, pt_idx, acc_cur, acc_inc;
    state_t              cur_state;
    logic                take, take_sof, take_eof;
    logic                fifo_empty, fifo_full, push, pop, drop;
    logic [ENT_W-1:0]    head;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        num_d      = num_q;
        short_d    = 1'b0;
        ovf_d      = ovf_q;
        take       = 1'b0;
        take_sof   = 1'b0;
        take_eof   = 1'b0;

        if (i_frame_sync) begin
            lo_d  = (i_start_index <= i_stop_index) ? i_start_index : i_stop_index;
            hi_d  = (i_start_index <= i_stop_index) ? i_stop_index : i_start_index;
            num_d = i_index_num;
        end
        cur_lo    = lo_d;
        cur_hi    = hi_d;
        cur_num   = num_d;
        pt_idx    = i_frame_sync ? 16'd0 : cnt_q;
        cur_state = i_frame_sync ? ARMED : state_q;
        acc_cur   = i_frame_sync ? 16'd0 : acc_q;
        acc_inc   = (acc_cur == 16'hFFFF) ? 16'hFFFF : acc_cur + 16'd1;
        short_d   = i_frame_sync && (state_q == ARMED || state_q == PASS);
        state_d   = cur_state;
        acc_d     = acc_cur;

        if (i_point_valid) begin
            cnt_d = (pt_idx == 16'hFFFF) ? 16'hFFFF : pt_idx + 16'd1;
            case (cur_state)
                ARMED: begin
                    take     = (pt_idx >= cur_lo) && (pt_idx <= cur_hi);
                    take_sof = take;
                end
                PASS:    take = (pt_idx <= cur_hi);
                default: take = 1'b0;
            endcase
        end else if (i_frame_sync) begin
            cnt_d = 16'd0;
        end

        if (take) begin
            take_eof = (acc_inc == cur_num) || (pt_idx == cur_hi);
            acc_d    = acc_inc;
            state_d  = take_eof ? DONE : PASS;
        end

        s0_valid_d = take;
        s0_sof_d   = take_sof;
        s0_eof_d   = take_eof;
        s0_index_d = pt_idx;
        s0_data_d  = i_point_data;

        s1_valid_d = s0_valid_q;
        s1_sof_d   = s0_sof_q;
        s1_eof_d   = s0_eof_q;
        s1_index_d = s0_index_q;
        s1_data_d  = s0_data_q;

        // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !fifo_empty && i_ready;
        push       = s1_valid_q && (!fifo_full || pop);
        drop       = s1_valid_q && fifo_full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        if (i_frame_sync) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            lo_q       <= 16'd450;
            hi_q       <= 16'd3150;
            num_q      <= 16'd2701;
            short_q    <= 1'b0;
            ovf_q      <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_sof_q   <= 1'b0;
            s0_eof_q   <= 1'b0;
            s0_index_q <= '0;
            s0_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s1_index_q <= '0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            num_q      <= num_d;
            short_q    <= short_d;
            ovf_q      <= ovf_d;
            s0_valid_q <= s0_valid_d;
            s0_sof_q   <= s0_sof_d;
            s0_eof_q   <= s0_eof_d;
            s0_index_q <= s0_index_d;
            s0_data_q  <= s0_data_d;
            s1_valid_q <= s1_valid_d;
            s1_sof_q   <= s1_sof_d;
            s1_eof_q   <= s1_eof_d;
            s1_index_q <= s1_index_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage has no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge i_clk_50m) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {s1_sof_q, s1_eof_q, s1_index_q, s1_data_q};
        end
    end

    // Head is masked while empty so stale storage never reaches the outputs.
    assign head          = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign o_valid       = !fifo_empty;
    assign o_data        = head[DATA_W-1:0];
    assign o_index       = head[DATA_W+15:DATA_W];
    assign o_eof         = head[DATA_W+16];
    assign o_sof         = head[DATA_W+17];
    assign o_overflow    = ovf_q;
    assign o_short_frame = short_q;

`ifdef SCAN_GATE_COUNT_CHECK_EN
    logic count_err_q, count_err_d;

    always_comb begin
        count_err_d = i_frame_sync && (state_q == DONE) && (acc_q != num_q);
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            count_err_q <= 1'b0;
        end else begin
            count_err_q <= count_err_d;
        end
    end

    assign o_count_err = count_err_q;
`endif

endmodule
